// File: rtl/trap_req_gen.sv
// trap_req_gen
// Trap initiator for the machine-mode CSR unit. Collects synchronous exceptions
// (illegal, ebreak, ecall) from execute and the machine timer interrupt. The
// winning cause is prioritised and held as a single outstanding request (cause,
// epc) until the CSR unit acknowledges it. Handler occupancy is tracked until
// mret returns the hart to normal execution. The block also owns the
// memory-mapped 64-bit mtime/mtimecmp timer.

module trap_req_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EXU_i_valid,
    input  logic [31:0] EXU_i_pc,
    input  logic        EXU_i_illegal,
    input  logic        EXU_i_ebreak,
    input  logic        EXU_i_ecall,
    input  logic        EXU_i_mret,
    input  logic        CSR_i_mie,
    input  logic        CSR_i_mtie,
    input  logic        CSR_i_ack,
    input  logic        TMR_i_wen,
    input  logic [3:0]  TMR_i_addr,
    input  logic [31:0] TMR_i_wdata,
    output logic [31:0] TMR_o_rdata,
    output logic        TRAP_o_req,
    output logic [31:0] TRAP_o_cause,
    output logic [31:0] TRAP_o_epc,
    output logic        TRAP_o_stall,
    output logic        TRAP_o_mret,
    output logic        TRAP_o_mtip
);

    // Prescaler width: a single bit is kept even when every cycle is a tick,
    // so the counter is never zero-width.
    localparam int unsigned       PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

    localparam logic [3:0] ADDR_MTIME_LO = 4'h0;
    localparam logic [3:0] ADDR_MTIME_HI = 4'h4;
    localparam logic [3:0] ADDR_CMP_LO   = 4'h8;
    localparam logic [3:0] ADDR_CMP_HI   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_INTRAP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_r;
    logic [63:0]      mtime_r;
    logic [63:0]      mtimecmp_r;
    state_t           state_r;
    logic             req_r;
    logic [31:0]      cause_r;
    logic [31:0]      epc_r;
    logic             mret_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             tick_s;
    logic [PRE_W-1:0] pre_nxt_s;
    logic [63:0]      mtime_nxt_s;
    logic [63:0]      mtimecmp_nxt_s;
    logic [31:0]      rdata_s;
    logic             mtip_s;
    logic             exc_s;
    logic             irq_s;
    logic             take_s;
    logic [31:0]      sel_cause_s;
    logic             mret_acc_s;

    // Pending compare works on the registered timer values only.
    assign mtip_s = (mtime_r >= mtimecmp_r);

    // Prescaler: count 0..TICK_DIV-1 and flag the wrap as an mtime tick.
    always_comb begin
        tick_s    = 1'b0;
        pre_nxt_s = pre_r;
        if (pre_r == PRE_LAST) begin
            tick_s    = 1'b1;
            pre_nxt_s = '0;
        end else begin
            tick_s    = 1'b0;
            pre_nxt_s = pre_r + PRE_W'(1'b1);
        end
    end

    // Next mtime: a software write to either half replaces that half and
    // suppresses the tick for that cycle; otherwise advance on a tick.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (TMR_i_wen && (TMR_i_addr == ADDR_MTIME_LO)) begin
            mtime_nxt_s = {mtime_r[63:32], TMR_i_wdata};
        end else if (TMR_i_wen && (TMR_i_addr == ADDR_MTIME_HI)) begin
            mtime_nxt_s = {TMR_i_wdata, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Next mtimecmp: plain half-word writes, nothing else changes it.
    always_comb begin
        mtimecmp_nxt_s = mtimecmp_r;
        if (TMR_i_wen && (TMR_i_addr == ADDR_CMP_LO)) begin
            mtimecmp_nxt_s = {mtimecmp_r[63:32], TMR_i_wdata};
        end else if (TMR_i_wen && (TMR_i_addr == ADDR_CMP_HI)) begin
            mtimecmp_nxt_s = {TMR_i_wdata, mtimecmp_r[31:0]};
        end else begin
            mtimecmp_nxt_s = mtimecmp_r;
        end
    end

    // Timer read mux; unmapped offsets read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (TMR_i_addr)
            ADDR_MTIME_LO: rdata_s = mtime_r[31:0];
            ADDR_MTIME_HI: rdata_s = mtime_r[63:32];
            ADDR_CMP_LO:   rdata_s = mtimecmp_r[31:0];
            ADDR_CMP_HI:   rdata_s = mtimecmp_r[63:32];
            default:       rdata_s = 32'd0;
        endcase
    end

    // Timer state: prescaler, mtime and mtimecmp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r      <= '0;
            mtime_r    <= 64'd0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            pre_r      <= pre_nxt_s;
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
        end
    end

    // Trap selection. Execute inputs are ignored while a request is
    // outstanding. The timer interrupt is only taken outside a handler, and
    // an mret is accepted only when the same instruction is not trapping.
    always_comb begin
        exc_s       = 1'b0;
        irq_s       = 1'b0;
        take_s      = 1'b0;
        sel_cause_s = 32'd0;
        mret_acc_s  = 1'b0;
        if (EXU_i_valid && (state_r != ST_REQ)) begin
            exc_s = EXU_i_illegal | EXU_i_ebreak | EXU_i_ecall;
            irq_s = (state_r == ST_IDLE) & CSR_i_mie & CSR_i_mtie & mtip_s;
            if (EXU_i_illegal) begin
                sel_cause_s = CAUSE_ILLEGAL;
            end else if (EXU_i_ebreak) begin
                sel_cause_s = CAUSE_EBREAK;
            end else if (EXU_i_ecall) begin
                sel_cause_s = CAUSE_ECALL;
            end else if (irq_s) begin
                sel_cause_s = CAUSE_MTI;
            end else begin
                sel_cause_s = 32'd0;
            end
            take_s     = exc_s | irq_s;
            mret_acc_s = EXU_i_mret & ~take_s;
        end else begin
            exc_s       = 1'b0;
            irq_s       = 1'b0;
            take_s      = 1'b0;
            sel_cause_s = 32'd0;
            mret_acc_s  = 1'b0;
        end
    end

    // Trap FSM with registered request, cause, epc and mret pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            cause_r <= 32'd0;
            epc_r   <= 32'd0;
            mret_r  <= 1'b0;
        end else begin
            mret_r <= mret_acc_s;
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        cause_r <= sel_cause_s;
                        epc_r   <= EXU_i_pc;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (CSR_i_ack) begin
                        state_r <= ST_INTRAP;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end
                end
                ST_INTRAP: begin
                    if (take_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        cause_r <= sel_cause_s;
                        epc_r   <= EXU_i_pc;
                    end else if (mret_acc_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INTRAP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign TMR_o_rdata  = rdata_s;
    assign TRAP_o_req   = req_r;
    assign TRAP_o_cause = cause_r;
    assign TRAP_o_epc   = epc_r;
    assign TRAP_o_mret  = mret_r;
    assign TRAP_o_mtip  = mtip_s;
    assign TRAP_o_stall = (state_r == ST_REQ) | take_s;

endmodule

// File: tb/tb_trap_req_gen.sv
// Self-checking bench for trap_req_gen: hand-written vector table, directed
// timer / reset sequences and a randomized run against a reference model.

module tb_trap_req_gen;

    localparam int unsigned TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EXU_i_valid = 1'b0;
    logic [31:0] EXU_i_pc = 32'd0;
    logic        EXU_i_illegal = 1'b0;
    logic        EXU_i_ebreak = 1'b0;
    logic        EXU_i_ecall = 1'b0;
    logic        EXU_i_mret = 1'b0;
    logic        CSR_i_mie = 1'b0;
    logic        CSR_i_mtie = 1'b0;
    logic        CSR_i_ack = 1'b0;
    logic        TMR_i_wen = 1'b0;
    logic [3:0]  TMR_i_addr = 4'h0;
    logic [31:0] TMR_i_wdata = 32'd0;
    logic [31:0] TMR_o_rdata;
    logic        TRAP_o_req;
    logic [31:0] TRAP_o_cause;
    logic [31:0] TRAP_o_epc;
    logic        TRAP_o_stall;
    logic        TRAP_o_mret;
    logic        TRAP_o_mtip;

    trap_req_gen #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .EXU_i_valid(EXU_i_valid), .EXU_i_pc(EXU_i_pc),
        .EXU_i_illegal(EXU_i_illegal), .EXU_i_ebreak(EXU_i_ebreak),
        .EXU_i_ecall(EXU_i_ecall), .EXU_i_mret(EXU_i_mret),
        .CSR_i_mie(CSR_i_mie), .CSR_i_mtie(CSR_i_mtie), .CSR_i_ack(CSR_i_ack),
        .TMR_i_wen(TMR_i_wen), .TMR_i_addr(TMR_i_addr), .TMR_i_wdata(TMR_i_wdata),
        .TMR_o_rdata(TMR_o_rdata),
        .TRAP_o_req(TRAP_o_req), .TRAP_o_cause(TRAP_o_cause), .TRAP_o_epc(TRAP_o_epc),
        .TRAP_o_stall(TRAP_o_stall), .TRAP_o_mret(TRAP_o_mret), .TRAP_o_mtip(TRAP_o_mtip)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_st: 0 = idle, 1 = request outstanding, 2 = inside handler
    logic [63:0] m_mtime, m_cmp;
    int          m_pre, m_st;
    logic        m_req, m_mret;
    logic [31:0] m_cause, m_epc;

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_pre = 0; m_st = 0;
        m_req = 1'b0; m_mret = 1'b0; m_cause = 32'd0; m_epc = 32'd0;
    endtask

    function automatic logic m_mtip();
        return m_mtime >= m_cmp;
    endfunction

    function automatic logic m_exc();
        return EXU_i_valid && (m_st != 1) && (EXU_i_illegal || EXU_i_ebreak || EXU_i_ecall);
    endfunction

    function automatic logic m_irq();
        return EXU_i_valid && (m_st == 0) && CSR_i_mie && CSR_i_mtie && m_mtip();
    endfunction

    function automatic logic m_stall();
        return (m_st == 1) || m_exc() || m_irq();
    endfunction

    function automatic logic [31:0] m_rdata();
        case (TMR_i_addr)
            4'h0: return m_mtime[31:0];
            4'h4: return m_mtime[63:32];
            4'h8: return m_cmp[31:0];
            4'hC: return m_cmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        take, ticked, mret_seen;
        logic [31:0] c;
        take = m_exc() || m_irq();
        mret_seen = EXU_i_valid && EXU_i_mret;
        if (EXU_i_illegal)     c = 32'd2;
        else if (EXU_i_ebreak) c = 32'd3;
        else if (EXU_i_ecall)  c = 32'd11;
        else                   c = 32'h8000_0007;
        m_mret = 1'b0;
        if (m_st == 1) begin
            if (CSR_i_ack) begin m_st = 2; m_req = 1'b0; end
        end else if (take) begin
            m_st = 1; m_req = 1'b1; m_cause = c; m_epc = EXU_i_pc;
        end else if (mret_seen) begin
            m_mret = 1'b1; m_st = 0;
        end
        ticked = (m_pre == int'(TICK_DIV) - 1);
        m_pre  = ticked ? 0 : m_pre + 1;
        if (TMR_i_wen && TMR_i_addr == 4'h0)      m_mtime[31:0]  = TMR_i_wdata;
        else if (TMR_i_wen && TMR_i_addr == 4'h4) m_mtime[63:32] = TMR_i_wdata;
        else if (ticked)                          m_mtime        = m_mtime + 64'd1;
        if (TMR_i_wen && TMR_i_addr == 4'h8)      m_cmp[31:0]    = TMR_i_wdata;
        else if (TMR_i_wen && TMR_i_addr == 4'hC) m_cmp[63:32]   = TMR_i_wdata;
    endtask

    // One clock: compare everything against the model mid-cycle, advance the
    // model with the inputs in force, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        chk("m_stall", TRAP_o_stall, m_stall());
        chk("m_mtip",  TRAP_o_mtip,  m_mtip());
        chk("m_rdata", TMR_o_rdata,  m_rdata());
        chk("m_req",   TRAP_o_req,   m_req);
        chk("m_cause", TRAP_o_cause, m_cause);
        chk("m_epc",   TRAP_o_epc,   m_epc);
        chk("m_mret",  TRAP_o_mret,  m_mret);
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic clr_exu();
        EXU_i_valid = 1'b0; EXU_i_pc = 32'd0; EXU_i_illegal = 1'b0;
        EXU_i_ebreak = 1'b0; EXU_i_ecall = 1'b0; EXU_i_mret = 1'b0;
        CSR_i_ack = 1'b0; TMR_i_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_exu();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        TMR_i_addr = a;
        #1 chk(name, TMR_o_rdata, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        ill, ebk, ecl, mrt, ack;
        logic        x_stall, x_req;
        logic [31:0] x_cause, x_epc;
        logic        x_mret;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic v, input logic [31:0] pc,
                                input logic ill, ebk, ecl, mrt, ack,
                                input logic xs, xr, input logic [31:0] xc, xe,
                                input logic xm);
        vec_t r;
        r.v = v; r.pc = pc; r.ill = ill; r.ebk = ebk; r.ecl = ecl; r.mrt = mrt; r.ack = ack;
        r.x_stall = xs; r.x_req = xr; r.x_cause = xc; r.x_epc = xe; r.x_mret = xm;
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(1, 32'h8000_0010, 0,0,1,0,0, 1,1, 32'd11, 32'h8000_0010, 0);
        vecs[1]  = mk(0, 32'h0,         0,0,0,0,0, 1,1, 32'd11, 32'h8000_0010, 0);
        vecs[2]  = mk(0, 32'h0,         0,0,0,0,0, 1,1, 32'd11, 32'h8000_0010, 0);
        vecs[3]  = mk(0, 32'h0,         0,0,0,0,0, 1,1, 32'd11, 32'h8000_0010, 0);
        vecs[4]  = mk(0, 32'h0,         0,0,0,0,1, 1,0, 32'd11, 32'h8000_0010, 0);
        vecs[5]  = mk(1, 32'h100,       0,0,0,1,0, 0,0, 32'd11, 32'h8000_0010, 1);
        vecs[6]  = mk(0, 32'h0,         0,0,0,0,0, 0,0, 32'd11, 32'h8000_0010, 0);
        vecs[7]  = mk(1, 32'h200,       1,0,1,0,0, 1,1, 32'd2,  32'h200, 0);
        vecs[8]  = mk(1, 32'h300,       0,1,0,0,1, 1,0, 32'd2,  32'h200, 0);
        vecs[9]  = mk(1, 32'h400,       0,0,1,0,0, 1,1, 32'd11, 32'h400, 0);
        vecs[10] = mk(0, 32'h0,         0,0,0,0,1, 1,0, 32'd11, 32'h400, 0);
        vecs[11] = mk(1, 32'h500,       0,1,0,1,0, 1,1, 32'd3,  32'h500, 0);
        vecs[12] = mk(1, 32'h504,       0,0,0,1,1, 1,0, 32'd3,  32'h500, 0);
        vecs[13] = mk(1, 32'h508,       0,0,0,1,0, 0,0, 32'd3,  32'h500, 1);
        vecs[14] = mk(1, 32'h50C,       0,0,0,1,0, 0,0, 32'd3,  32'h500, 1);
        vecs[15] = mk(0, 32'h0,         0,0,0,0,0, 0,0, 32'd3,  32'h500, 0);
        vecs[16] = mk(1, 32'h600,       0,1,0,0,1, 1,1, 32'd3,  32'h600, 0);
        vecs[17] = mk(0, 32'h0,         0,0,0,0,1, 1,0, 32'd3,  32'h600, 0);
        vecs[18] = mk(0, 32'h0,         0,0,0,0,0, 0,0, 32'd3,  32'h600, 0);
        vecs[19] = mk(1, 32'h604,       0,0,0,1,0, 0,0, 32'd3,  32'h600, 1);
        vecs[20] = mk(0, 32'h0,         0,0,1,0,0, 0,0, 32'd3,  32'h600, 0);

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_req",   TRAP_o_req,   1'b0);
        chk("rst_cause", TRAP_o_cause, 32'd0);
        chk("rst_epc",   TRAP_o_epc,   32'd0);
        chk("rst_mret",  TRAP_o_mret,  1'b0);
        chk("rst_mtip",  TRAP_o_mtip,  1'b0);
        rd_chk("rst_cmp_lo",   4'h8, 32'hFFFF_FFFF);
        rd_chk("rst_mtime_lo", 4'h0, 32'd0);

        // ---------------- table: handshake, priority, nesting, mret ----------------
        for (int i = 0; i < 21; i++) begin
            EXU_i_valid = vecs[i].v; EXU_i_pc = vecs[i].pc;
            EXU_i_illegal = vecs[i].ill; EXU_i_ebreak = vecs[i].ebk;
            EXU_i_ecall = vecs[i].ecl; EXU_i_mret = vecs[i].mrt; CSR_i_ack = vecs[i].ack;
            #1 chk($sformatf("vec%0d_stall", i), TRAP_o_stall, vecs[i].x_stall);
            tick();
            chk($sformatf("vec%0d_req", i),   TRAP_o_req,   vecs[i].x_req);
            chk($sformatf("vec%0d_cause", i), TRAP_o_cause, vecs[i].x_cause);
            chk($sformatf("vec%0d_epc", i),   TRAP_o_epc,   vecs[i].x_epc);
            chk($sformatf("vec%0d_mret", i),  TRAP_o_mret,  vecs[i].x_mret);
        end
        clr_exu();

        // ---------------- timer interrupt, TICK_DIV=4, mtimecmp=10 ----------------
        do_reset();
        CSR_i_mie = 1'b1; CSR_i_mtie = 1'b1;
        TMR_i_wen = 1'b1; TMR_i_addr = 4'h8; TMR_i_wdata = 32'd10;
        tick();                                   // edge 1
        TMR_i_addr = 4'hC; TMR_i_wdata = 32'd0;
        tick();                                   // edge 2
        TMR_i_wen = 1'b0; TMR_i_addr = 4'h0;
        repeat (37) tick();                       // edge 39
        chk("mtip_c39", TRAP_o_mtip, 1'b0);
        tick();                                   // edge 40
        chk("mtip_c40", TRAP_o_mtip, 1'b1);
        rd_chk("mtime_c40", 4'h0, 32'd10);
        EXU_i_valid = 1'b1; EXU_i_pc = 32'h0000_1234;
        #1 chk("irq_stall", TRAP_o_stall, 1'b1);
        tick();
        chk("irq_req",   TRAP_o_req,   1'b1);
        chk("irq_cause", TRAP_o_cause, 32'h8000_0007);
        chk("irq_epc",   TRAP_o_epc,   32'h0000_1234);
        EXU_i_valid = 1'b0; CSR_i_ack = 1'b1;
        tick();
        CSR_i_ack = 1'b0; EXU_i_valid = 1'b1; EXU_i_pc = 32'h0000_1238;
        #1 chk("irq_in_handler_stall", TRAP_o_stall, 1'b0);
        tick();
        chk("irq_in_handler_req", TRAP_o_req, 1'b0);
        EXU_i_mret = 1'b1; EXU_i_pc = 32'h0000_123C;
        tick();
        chk("irq_mret_pulse", TRAP_o_mret, 1'b1);
        EXU_i_mret = 1'b0; EXU_i_pc = 32'h0000_2000;
        tick();
        chk("irq_retaken_req",   TRAP_o_req,   1'b1);
        chk("irq_retaken_cause", TRAP_o_cause, 32'h8000_0007);
        EXU_i_valid = 1'b0; CSR_i_ack = 1'b1;
        tick();
        CSR_i_ack = 1'b0; EXU_i_valid = 1'b1; EXU_i_mret = 1'b1;
        tick();
        clr_exu();
        CSR_i_mie = 1'b0;

        // ---------------- mtime wrap and write-during-tick ----------------
        for (int i = 0; i < 8 && m_pre != 1; i++) tick();
        TMR_i_wen = 1'b1; TMR_i_addr = 4'h4; TMR_i_wdata = 32'hFFFF_FFFF;
        tick();
        TMR_i_addr = 4'h0;
        tick();
        TMR_i_wen = 1'b0;
        rd_chk("wrap_pre_hi", 4'h4, 32'hFFFF_FFFF);
        rd_chk("wrap_pre_lo", 4'h0, 32'hFFFF_FFFF);
        chk("wrap_pre_mtip", TRAP_o_mtip, 1'b1);
        tick();
        rd_chk("wrap_post_lo", 4'h0, 32'd0);
        rd_chk("wrap_post_hi", 4'h4, 32'd0);
        chk("wrap_post_mtip", TRAP_o_mtip, 1'b0);
        for (int i = 0; i < 8 && m_pre != int'(TICK_DIV) - 1; i++) tick();
        TMR_i_wen = 1'b1; TMR_i_addr = 4'h0; TMR_i_wdata = 32'h55;
        tick();
        TMR_i_wen = 1'b0;
        rd_chk("wr_on_tick", 4'h0, 32'h55);
        tick();
        rd_chk("wr_on_tick_next", 4'h0, 32'h55);
        TMR_i_wen = 1'b1; TMR_i_addr = 4'h2; TMR_i_wdata = 32'hDEAD;
        tick();
        TMR_i_wen = 1'b0;
        rd_chk("unmapped_rd", 4'h2, 32'd0);
        rd_chk("unmapped_wr_no_effect", 4'h0, 32'h55);

        // ---------------- asynchronous reset while a request is pending ----------------
        EXU_i_valid = 1'b1; EXU_i_ecall = 1'b1; EXU_i_pc = 32'h4444;
        tick();
        clr_exu();
        chk("pre_rst_req", TRAP_o_req, 1'b1);
        TMR_i_addr = 4'h8;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req",  TRAP_o_req,  1'b0);
        chk("async_rst_mtip", TRAP_o_mtip, 1'b0);
        chk("async_rst_cmp_lo", TMR_o_rdata, 32'hFFFF_FFFF);
        rd_chk("async_rst_cmp_hi", 4'hC, 32'hFFFF_FFFF);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_req", TRAP_o_req, 1'b0);
        end

        // ---------------- randomized run against the model ----------------
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                CSR_i_mie  = ($urandom % 4) != 0;
                CSR_i_mtie = ($urandom % 4) != 0;
            end
            EXU_i_valid   = ($urandom % 4) != 0;
            EXU_i_pc      = $urandom & 32'hFFFF_FFFC;
            EXU_i_illegal = ($urandom % 10) == 0;
            EXU_i_ebreak  = ($urandom % 12) == 0;
            EXU_i_ecall   = ($urandom % 8) == 0;
            EXU_i_mret    = ($urandom % 6) == 0;
            CSR_i_ack     = ($urandom % 2) == 0;
            TMR_i_wen     = ($urandom % 20) == 0;
            TMR_i_addr    = 4'($urandom % 16);
            TMR_i_wdata   = (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 300);
            tick();
        end
        clr_exu();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
